// File: rtl/hi6110_pkg.sv
// Shared constants, FSM state type and status-word helpers for the HI-6110 host-side receive path.
package hi6110_pkg;

  localparam logic [3:0] RX_STATUS_ADDR = 4'h1;
  localparam logic [3:0] RX_DATA_ADDR   = 4'h2;
  localparam int         STAT_VALID_BIT = 15;
  localparam int         STAT_CNT_MSB   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_STAT,
    ST_DECODE,
    ST_RD_DATA,
    ST_WAIT_SPACE
  } rx_state_e;

  function automatic logic in_window(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // A zero count field means a full 32-word message.
  function automatic logic [STAT_CNT_MSB+1:0] stat_word_count(input logic [15:0] stat);
    if (stat[STAT_CNT_MSB:0] == '0)
      return (STAT_CNT_MSB+2)'(1 << (STAT_CNT_MSB + 1));
    return {1'b0, stat[STAT_CNT_MSB:0]};
  endfunction

endpackage

// File: rtl/hi6110_rx_fifo.sv
// Synchronous FIFO with full/empty/count; tolerates push and pop in the same clock when full.
module hi6110_rx_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  // NOTE: storage is deliberately not reset; resetting the pointers alone empties the FIFO.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/hi6110_rx_reader.sv
// HI-6110 receive engine: timed status/data bus reads into a FIFO, drained as a valid/ready stream.
// Optional HI6110_RX_STATS_EN adds msg_cnt / bad_stat_cnt outputs.
module hi6110_rx_reader
  import hi6110_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int CS_START   = 5,
  parameter int STR_START  = 10,
  parameter int STR_END    = 18,
  parameter int CS_END     = 25,
  parameter int CYC_LEN    = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rcv_irq_n,
  output logic [3:0]  reg_addr,
  input  logic [15:0] reg_data_i,
  output logic        cs_n,
  output logic        rw,
  output logic        str_n,
  output logic [15:0] m_data,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy,
  output logic        err_pulse
`ifdef HI6110_RX_STATS_EN
  ,
  output logic [15:0] msg_cnt,
  output logic [15:0] bad_stat_cnt
`endif
);

  localparam int             CW     = $clog2(CYC_LEN);
  localparam int             NW     = STAT_CNT_MSB + 2;
  localparam int             FCW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  C_LAST = CW'(CYC_LEN - 1);

  logic            irq_s1_q, irq_s2_q;
  rx_state_e       state_q;
  logic [CW-1:0]   c_q;
  logic [NW-1:0]   left_q;
  logic [15:0]     rdata_q;
  logic [3:0]      addr_q;
  logic            cs_n_q, str_n_q, err_q;
  logic            cyc_end, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [16:0]     fifo_wdata, fifo_rdata;
  logic [FCW-1:0]  fifo_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_s1_q <= 1'b1;
      irq_s2_q <= 1'b1;
    end else begin
      irq_s1_q <= rcv_irq_n;
      irq_s2_q <= irq_s1_q;
    end
  end

  assign cyc_end    = (c_q == C_LAST);
  assign fifo_push  = (state_q == ST_RD_DATA) && cyc_end;
  assign fifo_wdata = {left_q == NW'(1), rdata_q};
  assign fifo_pop   = m_valid && m_ready;

  // NOTE: non-blocking assignments so every branch sees the pre-edge state and counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      left_q  <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      cs_n_q  <= 1'b1;
      str_n_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      err_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      str_n_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!irq_s2_q) begin
            state_q <= ST_RD_STAT;
            c_q     <= '0;
            addr_q  <= RX_STATUS_ADDR;
          end
        end
        ST_RD_STAT, ST_RD_DATA: begin
          // A data cycle only leaves count 0 once a FIFO slot is guaranteed for its word.
          if (state_q == ST_RD_DATA && c_q == '0 && fifo_full) begin
            state_q <= ST_WAIT_SPACE;
          end else begin
            cs_n_q  <= !in_window(int'(c_q), CS_START, CS_END);
            str_n_q <= !in_window(int'(c_q), STR_START, STR_END);
            if (int'(c_q) == STR_END) rdata_q <= reg_data_i;
            c_q <= cyc_end ? '0 : c_q + 1'b1;
            if (cyc_end) begin
              if (state_q == ST_RD_STAT)  state_q <= ST_DECODE;
              else if (left_q == NW'(1))  state_q <= ST_IDLE;
              else                        left_q  <= left_q - 1'b1;
            end
          end
        end
        ST_DECODE: begin
          if (rdata_q[STAT_VALID_BIT]) begin
            left_q  <= stat_word_count(rdata_q);
            addr_q  <= RX_DATA_ADDR;
            c_q     <= '0;
            state_q <= ST_RD_DATA;
          end else begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT_SPACE: begin
          if (fifo_count < FCW'(FIFO_DEPTH)) state_q <= ST_RD_DATA;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  hi6110_rx_fifo #(
    .WIDTH (17),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef HI6110_RX_STATS_EN
  logic [15:0] msg_cnt_q, bad_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      msg_cnt_q <= '0;
      bad_cnt_q <= '0;
    end else begin
      if (fifo_push && left_q == NW'(1)) msg_cnt_q <= msg_cnt_q + 1'b1;
      if (state_q == ST_DECODE && !rdata_q[STAT_VALID_BIT]) bad_cnt_q <= bad_cnt_q + 1'b1;
    end
  end

  assign msg_cnt      = msg_cnt_q;
  assign bad_stat_cnt = bad_cnt_q;
`endif

  assign reg_addr  = addr_q;
  assign cs_n      = cs_n_q;
  assign str_n     = str_n_q;
  assign rw        = 1'b1;
  assign busy      = (state_q != ST_IDLE);
  assign err_pulse = err_q;
  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_rdata[15:0];
  assign m_last    = fifo_rdata[16] && !fifo_empty;

endmodule

// File: tb/tb_hi6110_rx_reader.sv
// Scoreboard bench for hi6110_rx_reader: a bus responder feeds queued words, a monitor checks stream/pins.
`timescale 1ns/1ps
module tb_hi6110_rx_reader;
  import hi6110_pkg::*;

  localparam int CS_START = 5, STR_START = 10, STR_END = 18, CS_END = 25, CYC_LEN = 32;

  logic        clk = 1'b0, rstn = 1'b0, rcv_irq_n = 1'b1, m_ready = 1'b0;
  logic [15:0] reg_data_i = 16'hDEAD;
  logic [3:0]  reg_addr;
  logic        cs_n, rw, str_n, m_last, m_valid, busy, err_pulse;
  logic [15:0] m_data;
`ifdef HI6110_RX_STATS_EN
  logic [15:0] msg_cnt, bad_stat_cnt;
`endif

  int vectors = 0, miscompares = 0;
  logic [16:0] exp_q[$];
  logic [3:0]  exp_addr_q[$];
  logic [15:0] bus_q[$];
  int ready_mode = 2;
  bit period_chk = 0;
  int err_seen = 0, exp_err = 0, stat_msgs = 0, stat_bad = 0;
  int data_cycles = 0, stat_cycles = 0, cyc_clk = 0;

  always #5 clk = ~clk;

  hi6110_rx_reader dut (
    .clk(clk), .rstn(rstn), .rcv_irq_n(rcv_irq_n), .reg_addr(reg_addr), .reg_data_i(reg_data_i),
    .cs_n(cs_n), .rw(rw), .str_n(str_n), .m_data(m_data), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .err_pulse(err_pulse)
`ifdef HI6110_RX_STATS_EN
    , .msg_cnt(msg_cnt), .bad_stat_cnt(bad_stat_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: the device answers reads in order; each valid status yields N data reads/words.
  task automatic load_msg(input logic [15:0] stat, input bit rnd);
    int n;
    logic [15:0] w;
    bus_q.push_back(stat);
    exp_addr_q.push_back(RX_STATUS_ADDR);
    if (!stat[15]) begin
      exp_err++;
      stat_bad++;
      return;
    end
    n = (stat[4:0] == 5'd0) ? 32 : int'(stat[4:0]);
    for (int i = 0; i < n; i++) begin
      w = rnd ? 16'($urandom) : 16'(16'h1111 * (i + 1));
      bus_q.push_back(w);
      exp_addr_q.push_back(RX_DATA_ADDR);
      exp_q.push_back({(i == n - 1), w});
    end
    stat_msgs++;
  endtask

  always @(posedge cs_n) begin
    if (rstn === 1'b1 && bus_q.size() > 0) void'(bus_q.pop_front());
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b1;
    endcase
  end

  logic        prev_cs = 1'b1, prev_str = 1'b1, hold_pend = 1'b0, last_valid = 1'b0;
  logic [16:0] hold_word;
  logic [3:0]  last_addr = 4'h0;
  int          cs_len = 0, str_len = 0, since_cs = 0, last_fall = 0;

  always @(negedge clk) begin
    cyc_clk++;
    reg_data_i = (bus_q.size() > 0) ? bus_q[0] : 16'hDEAD;
    if (rstn !== 1'b1) begin
      prev_cs = 1'b1; prev_str = 1'b1; hold_pend = 1'b0; last_valid = 1'b0;
      cs_len = 0; str_len = 0; since_cs = 0;
    end else begin
      if (err_pulse) err_seen++;
      if (hold_pend) begin
        check("stream_hold_valid", 32'(m_valid), 32'd1);
        check("stream_hold_word", 32'({m_last, m_data}), 32'(hold_word));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) fail_now("stream_unexpected_word");
        else check("stream_word", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
      end
      hold_pend = m_valid && !m_ready;
      hold_word = {m_last, m_data};

      if (!cs_n && !prev_cs) since_cs++;
      if (!cs_n && prev_cs) begin
        if (exp_addr_q.size() == 0) fail_now("bus_unexpected_cycle");
        else check("cycle_addr", 32'(reg_addr), 32'(exp_addr_q.pop_front()));
        check("cycle_rw", 32'(rw), 32'd1);
        if (reg_addr == RX_DATA_ADDR) data_cycles++;
        if (reg_addr == RX_STATUS_ADDR) stat_cycles++;
        if (period_chk && last_valid)
          check("cycle_period", 32'(cyc_clk - last_fall),
                (reg_addr == RX_DATA_ADDR && last_addr == RX_DATA_ADDR) ? 32'(CYC_LEN) : 32'(CYC_LEN + 1));
        last_valid = period_chk;
        last_fall  = cyc_clk;
        last_addr  = reg_addr;
        since_cs   = 0;
      end
      if (!str_n && prev_str) check("str_fall_after_cs", 32'(since_cs), 32'(STR_START - CS_START));
      if (!cs_n) cs_len++;
      if (!str_n) str_len++;
      if (cs_n && !prev_cs) begin
        check("cs_low_len", 32'(cs_len), 32'(CS_END - CS_START + 1));
        check("addr_stable", 32'(reg_addr), 32'(last_addr));
        cs_len = 0;
      end
      if (str_n && !prev_str) begin
        check("str_low_len", 32'(str_len), 32'(STR_END - STR_START + 1));
        check("str_rise_before_cs", 32'(cs_n), 32'd0);
        str_len = 0;
      end
      prev_cs  = cs_n;
      prev_str = str_n;
    end
  end

  task automatic wait_cs_fall(input string name);
    int n = 0;
    while (cs_n !== 1'b0 && n < 200) begin @(posedge clk); #1; n++; end
    check(name, 32'(cs_n), 32'd0);
  endtask

  task automatic wait_stat_cycles(input string name, input int target);
    int n = 0;
    while (stat_cycles < target && n < 4000) begin @(posedge clk); #1; n++; end
    check(name, 32'(stat_cycles), 32'(target));
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0 || exp_addr_q.size() != 0) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_msg(input string name, input logic [15:0] stat, input bit rnd);
    load_msg(stat, rnd);
    rcv_irq_n = 1'b0;
    wait_cs_fall({name, "_start"});
    rcv_irq_n = 1'b1;
    wait_done(name, 4000);
  endtask

  initial begin
    int n, lows, base_d, base_s;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_str_n", 32'(str_n), 32'd1);
    check("rst_rw", 32'(rw), 32'd1);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(posedge clk);

    // 1: three fixed words, irq-to-cs latency and back-to-back cycle spacing.
    ready_mode = 2;
    period_chk = 1;
    load_msg(16'h8003, 1'b0);
    @(posedge clk);
    #1;
    rcv_irq_n = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (cs_n !== 1'b0 && n < 100);
    check("irq_to_cs_latency", 32'(n), 32'(2 + 1 + CS_START + 1));
    rcv_irq_n = 1'b1;
    wait_done("t1", 2000);
    period_chk = 0;

    // 2: zero count field means 32 words; random data and random back-pressure.
    ready_mode = 1;
    run_msg("t2", 16'h8000, 1'b1);

    // 3: invalid status -> one error pulse, no data cycles.
    base_d = data_cycles;
    run_msg("t3", 16'h0005, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check("t3_no_data_cycle", 32'(data_cycles), 32'(base_d));
    check("t3_err_pulses", 32'(err_seen), 32'(exp_err));
`ifdef HI6110_RX_STATS_EN
    check("t3_bad_stat_cnt", 32'(bad_stat_cnt), 32'(stat_bad));
`endif

    // 4: stalled sink, two full messages -> FIFO fills and the bus parks.
    ready_mode = 0;
    base_d = data_cycles;
    base_s = stat_cycles;
    load_msg(16'h8000, 1'b1);
    load_msg(16'h8000, 1'b1);
    rcv_irq_n = 1'b0;
    wait_stat_cycles("t4_second_status", base_s + 2);
    rcv_irq_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("t4_state_wait_space", 32'(dut.state_q), 32'(ST_WAIT_SPACE));
    check("t4_data_cycles_stored", 32'(data_cycles - base_d), 32'd32);
    check("t4_m_valid", 32'(m_valid), 32'd1);
    check("t4_busy", 32'(busy), 32'd1);
    lows = 0;
    repeat (40) begin @(negedge clk); if (cs_n !== 1'b1 || str_n !== 1'b1) lows++; end
    check("t4_bus_parked", 32'(lows), 32'd0);
    ready_mode = 1;
    wait_done("t4", 8000);

    // 5: asynchronous reset during the strobe, then restart on the still-low irq.
    ready_mode = 2;
    base_d = data_cycles;
    load_msg(16'h8004, 1'b1);
    rcv_irq_n = 1'b0;
    n = 0;
    while (data_cycles < base_d + 2 && n < 2000) begin @(posedge clk); #1; n++; end
    n = 0;
    while (str_n !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    check("t5_in_strobe", 32'(str_n), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("t5_rst_cs_n", 32'(cs_n), 32'd1);
    check("t5_rst_str_n", 32'(str_n), 32'd1);
    check("t5_rst_m_valid", 32'(m_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    bus_q.delete();
    stat_msgs = 0;
    stat_bad = 0;
    load_msg(16'h8002, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    wait_cs_fall("t5_restart");
    check("t5_restart_addr", 32'(reg_addr), 32'(RX_STATUS_ADDR));
    rcv_irq_n = 1'b1;
    wait_done("t5", 2000);

    // 6: irq held across two messages -> status reads follow immediately.
    ready_mode = 2;
    period_chk = 1;
    base_s = stat_cycles;
    load_msg(16'h8003, 1'b1);
    load_msg(16'h8005, 1'b1);
    rcv_irq_n = 1'b0;
    wait_stat_cycles("t6_second_status", base_s + 2);
    rcv_irq_n = 1'b1;
    wait_done("t6", 3000);
    period_chk = 0;
`ifdef HI6110_RX_STATS_EN
    check("t6_msg_cnt", 32'(msg_cnt), 32'(stat_msgs));
    check("t6_bad_stat_cnt", 32'(bad_stat_cnt), 32'(stat_bad));
`endif
    check("final_err_pulses", 32'(err_seen), 32'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
